// File: rtl/text_buffer.sv
// text_buffer
//   Text-mode character store that sits between vga_sync and the font ROM.
//   One 4-bit glyph code is kept per text cell. A byte stream (valid/ready)
//   writes glyphs at a wrapping write cursor, handles newline (0x0A) and
//   clear (0x0C), and discards everything else. The read side maps the beam
//   position to a cell, reads the glyph, and emits it with the matching font
//   coordinates and sync signals, all delayed by exactly two pixel clocks.
//
// Ports
//   clk, rst              pixel clock, asynchronous active-high reset
//   screenX, screenY      beam position from vga_sync
//   displayOn             active-video flag from vga_sync
//   hsync, vsync          sync pulses from vga_sync
//   in_valid, in_code     write stream byte
//   in_ready              byte accepted when in_valid & in_ready
//   cursor_col/row        current write cursor
//   character             glyph code for the font ROM (BLANK outside the text area)
//   font_x, font_y        pixel position inside the glyph
//   text_on               beam is on a visible text cell
//   hsync_out, vsync_out  sync pulses aligned with character

module text_buffer #(
  parameter int         COLS  = 100,
  parameter int         ROWS  = 37,
  parameter logic [3:0] BLANK = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] screenX,
  input  logic [8:0] screenY,
  input  logic       displayOn,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       in_valid,
  input  logic [7:0] in_code,
  output logic       in_ready,
  output logic [6:0] cursor_col,
  output logic [5:0] cursor_row,
  output logic [3:0] character,
  output logic [1:0] font_x,
  output logic [2:0] font_y,
  output logic       text_on,
  output logic       hsync_out,
  output logic       vsync_out
);

  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = $clog2(CELLS);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  logic [3:0]        r_mem [0:CELLS-1];

  state_t            r_state, w_nextState;
  logic [6:0]        r_curCol, w_nextCol;
  logic [5:0]        r_curRow, w_nextRow, w_rowInc;
  logic [ADDR_W-1:0] r_clrAddr, w_nextClr;
  logic [ADDR_W-1:0] w_curAddr, w_wAddr;
  logic [3:0]        w_wData;
  logic              w_we;

  logic [6:0]        w_col;
  logic [5:0]        w_row;
  logic [ADDR_W-1:0] w_rdAddr;
  logic              w_inside;

  logic [ADDR_W-1:0] r_s1Addr;
  logic              r_s1Inside, r_s1Disp, r_s1H, r_s1V;
  logic [1:0]        r_s1FontX;
  logic [2:0]        r_s1FontY;

  // Address arithmetic is done at full RAM address width; every in-range
  // cell (row < ROWS, col < COLS) fits without loss. Out-of-range beam
  // positions may alias, but their data is replaced by BLANK.
  assign w_curAddr = ADDR_W'(r_curRow) * ADDR_W'(COLS) + ADDR_W'(r_curCol);
  assign w_rowInc  = (r_curRow == 6'(ROWS - 1)) ? 6'd0 : r_curRow + 6'd1;

  assign w_col    = screenX[8:2];
  assign w_row    = screenY[8:3];
  assign w_rdAddr = ADDR_W'(w_row) * ADDR_W'(COLS) + ADDR_W'(w_col);
  // screenX >= 512 is right of the text area; without the top bit the
  // 7-bit column would wrap back onto the first columns.
  assign w_inside = !screenX[9] && (int'(w_col) < COLS) && (int'(w_row) < ROWS);

  assign cursor_col = r_curCol;
  assign cursor_row = r_curRow;

  // Write-side state register. Reset parks the FSM in CLEAR at address 0,
  // so a full clear always runs after rst is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_curCol  <= '0;
      r_curRow  <= '0;
      r_clrAddr <= '0;
    end else begin
      r_state   <= w_nextState;
      r_curCol  <= w_nextCol;
      r_curRow  <= w_nextRow;
      r_clrAddr <= w_nextClr;
    end
  end

  // Next-state, cursor update and RAM write-port selection.
  always_comb begin
    w_nextState = r_state;
    w_nextCol   = r_curCol;
    w_nextRow   = r_curRow;
    w_nextClr   = r_clrAddr;
    w_we        = 1'b0;
    w_wAddr     = w_curAddr;
    w_wData     = BLANK;
    in_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_code == 8'h0C) begin
            w_nextState = ST_CLEAR;
            w_nextClr   = '0;
          end else if (in_code == 8'h0A) begin
            w_nextCol = 7'd0;
            w_nextRow = w_rowInc;
          end else if (in_code[7:4] == 4'h0) begin
            w_we    = 1'b1;
            w_wData = in_code[3:0];
            if (r_curCol == 7'(COLS - 1)) begin
              w_nextCol = 7'd0;
              w_nextRow = w_rowInc;
            end else begin
              w_nextCol = r_curCol + 7'd1;
            end
          end
        end
      end
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_wAddr = r_clrAddr;
        w_wData = BLANK;
        if (r_clrAddr == ADDR_W'(CELLS - 1)) begin
          w_nextState = ST_IDLE;
          w_nextClr   = '0;
          w_nextCol   = 7'd0;
          w_nextRow   = 6'd0;
        end else begin
          w_nextClr = r_clrAddr + ADDR_W'(1);
        end
      end
      default: w_nextState = ST_CLEAR;
    endcase
  end

  // Glyph RAM write port (no reset: contents are defined by the clear).
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wAddr] <= w_wData;
  end

  // Read stage 1: cell address, in-area flag and everything that must
  // travel alongside the glyph.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1Addr   <= '0;
      r_s1Inside <= 1'b0;
      r_s1Disp   <= 1'b0;
      r_s1H      <= 1'b0;
      r_s1V      <= 1'b0;
      r_s1FontX  <= '0;
      r_s1FontY  <= '0;
    end else begin
      r_s1Addr   <= w_rdAddr;
      r_s1Inside <= w_inside;
      r_s1Disp   <= displayOn;
      r_s1H      <= hsync;
      r_s1V      <= vsync;
      r_s1FontX  <= screenX[1:0];
      r_s1FontY  <= screenY[2:0];
    end
  end

  // Read stage 2: synchronous RAM read. A write to the same address in this
  // cycle lands after the read, so the old glyph is returned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      character <= '0;
      text_on   <= 1'b0;
      font_x    <= '0;
      font_y    <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      character <= r_s1Inside ? r_mem[r_s1Addr] : BLANK;
      text_on   <= r_s1Inside & r_s1Disp;
      font_x    <= r_s1FontX;
      font_y    <= r_s1FontY;
      hsync_out <= r_s1H;
      vsync_out <= r_s1V;
    end
  end

endmodule

// File: tb/tb_text_buffer.sv
// tb_text_buffer
//   Directed bench for text_buffer: reset/clear timing, glyph writes and
//   cursor wrap, the two-cycle read pipeline, out-of-area blanking, and a
//   reset that interrupts a clear.

module tb_text_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] screenX;
  logic [8:0] screenY;
  logic       displayOn, hsync, vsync;
  logic       in_valid;
  logic [7:0] in_code;
  logic       in_ready;
  logic [6:0] cursor_col;
  logic [5:0] cursor_row;
  logic [3:0] character;
  logic [1:0] font_x;
  logic [2:0] font_y;
  logic       text_on, hsync_out, vsync_out;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic       disp;
    logic       hs;
    logic       vs;
    logic [3:0] expChar;
    logic       expTextOn;
  } vec_t;

  vec_t vecs[$];

  text_buffer dut (
    .clk(clk), .rst(rst),
    .screenX(screenX), .screenY(screenY),
    .displayOn(displayOn), .hsync(hsync), .vsync(vsync),
    .in_valid(in_valid), .in_code(in_code), .in_ready(in_ready),
    .cursor_col(cursor_col), .cursor_row(cursor_row),
    .character(character), .font_x(font_x), .font_y(font_y),
    .text_on(text_on), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic vec_t mkVec(input int x, input int y, input logic disp,
                                 input logic hs, input logic vs,
                                 input int ch, input logic ton);
    vec_t v;
    v.x = 10'(x); v.y = 9'(y); v.disp = disp; v.hs = hs; v.vs = vs;
    v.expChar = 4'(ch); v.expTextOn = ton;
    return v;
  endfunction

  // Drive one beam position, hold it, and compare two clocks later.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    screenX = v.x; screenY = v.y; displayOn = v.disp; hsync = v.hs; vsync = v.vs;
    @(posedge clk); @(posedge clk); #1;
    checkOutput($sformatf("vec%0d_character", idx), int'(character), int'(v.expChar));
    checkOutput($sformatf("vec%0d_font_x", idx), int'(font_x), int'(v.x[1:0]));
    checkOutput($sformatf("vec%0d_font_y", idx), int'(font_y), int'(v.y[2:0]));
    checkOutput($sformatf("vec%0d_text_on", idx), int'(text_on), int'(v.expTextOn));
    checkOutput($sformatf("vec%0d_hsync_out", idx), int'(hsync_out), int'(v.hs));
    checkOutput($sformatf("vec%0d_vsync_out", idx), int'(vsync_out), int'(v.vs));
  endtask

  task automatic readCell(input int col, input int row, output int ch);
    @(negedge clk);
    screenX = 10'(col * 4); screenY = 9'(row * 8); displayOn = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    ch = int'(character);
  endtask

  task automatic sendByte(input logic [7:0] c);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_code = c;
    n = 0;
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("sendByte_ready", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic waitClear(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!in_ready && n < 5000);
  endtask

  task automatic checkCursor(input string name, input int col, input int row);
    checkOutput({name, "_col"}, int'(cursor_col), col);
    checkOutput({name, "_row"}, int'(cursor_row), row);
  endtask

  initial begin
    int n, ch, bad;
    logic [9:0] xs[3];
    logic [3:0] chars[3];
    logic       insides[3];
    logic [15:0] hsPat, vsPat, dispPat;

    rst = 1'b1; in_valid = 1'b0; in_code = 8'h00;
    screenX = '0; screenY = '0; displayOn = 1'b0; hsync = 1'b0; vsync = 1'b0;

    // ---- reset state: outputs held at 0 even with active inputs
    repeat (3) @(posedge clk);
    @(negedge clk);
    hsync = 1'b1; vsync = 1'b1; displayOn = 1'b1; screenX = 10'd3; screenY = 9'd7;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("rst_in_ready", int'(in_ready), 0);
    checkCursor("rst_cursor", 0, 0);
    checkOutput("rst_character", int'(character), 0);
    checkOutput("rst_text_on", int'(text_on), 0);
    checkOutput("rst_hsync_out", int'(hsync_out), 0);
    checkOutput("rst_font_x", int'(font_x), 0);

    // ---- release reset: initial clear lasts exactly COLS*ROWS cycles
    @(negedge clk);
    hsync = 1'b0; vsync = 1'b0; displayOn = 1'b0; screenX = '0; screenY = '0;
    rst = 1'b0;
    waitClear(n);
    checkOutput("initClear_cycles", n, 3700);
    checkCursor("initClear_cursor", 0, 0);

    bad = 0;
    for (int r = 0; r < 37; r++)
      for (int c = 0; c < 100; c++) begin
        readCell(c, r, ch);
        if (ch != 0) bad++;
      end
    checkOutput("initClear_nonBlankCells", bad, 0);

    // ---- 100 glyphs across row 0; first is 0x05, code (i+5)%16 with 0xA/0xC replaced by 7
    for (int i = 0; i < 100; i++) begin
      n = (i + 5) % 16;
      if (n == 10 || n == 12) n = 7;
      sendByte(8'(n));
      if (i == 98) checkCursor("row0_after99", 99, 0);
    end
    checkCursor("row0_after100", 0, 1);

    // ---- table: glyph 5 across the whole (0,0) cell, neighbours, area edges
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 4; x++)
        vecs.push_back(mkVec(x, y, 1'b1, x[0], y[0], 5, 1'b1));
    vecs.push_back(mkVec(4,   0,   1'b1, 1'b0, 1'b1, 6, 1'b1));
    vecs.push_back(mkVec(396, 0,   1'b1, 1'b1, 1'b0, 8, 1'b1));
    vecs.push_back(mkVec(0,   8,   1'b1, 1'b0, 1'b0, 0, 1'b1));
    vecs.push_back(mkVec(399, 295, 1'b1, 1'b1, 1'b1, 0, 1'b1));
    vecs.push_back(mkVec(400, 0,   1'b1, 1'b0, 1'b1, 0, 1'b0));
    vecs.push_back(mkVec(0,   296, 1'b1, 1'b1, 1'b0, 0, 1'b0));
    vecs.push_back(mkVec(420, 10,  1'b0, 1'b1, 1'b1, 0, 1'b0));
    vecs.push_back(mkVec(420, 10,  1'b1, 1'b0, 1'b1, 0, 1'b0));
    vecs.push_back(mkVec(3,   2,   1'b0, 1'b0, 1'b0, 5, 1'b0));
    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // ---- streaming sequence: inputs change every cycle, outputs must trail by two
    xs[0] = 10'd0;   chars[0] = 4'd5; insides[0] = 1'b1;
    xs[1] = 10'd4;   chars[1] = 4'd6; insides[1] = 1'b1;
    xs[2] = 10'd420; chars[2] = 4'd0; insides[2] = 1'b0;
    hsPat = 16'hB3A5; vsPat = 16'h5C6E; dispPat = 16'hE9D3;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (k < 16) begin
        screenX = xs[k % 3]; screenY = 9'(k % 8);
        hsync = hsPat[k]; vsync = vsPat[k]; displayOn = dispPat[k];
      end
      @(posedge clk); #1;
      if (k >= 1) begin
        int j;
        j = k - 1;
        checkOutput($sformatf("stream%0d_character", j), int'(character), int'(chars[j % 3]));
        checkOutput($sformatf("stream%0d_font_x", j), int'(font_x), int'(xs[j % 3][1:0]));
        checkOutput($sformatf("stream%0d_font_y", j), int'(font_y), j % 8);
        checkOutput($sformatf("stream%0d_text_on", j), int'(text_on),
                    int'(dispPat[j] & insides[j % 3]));
        checkOutput($sformatf("stream%0d_hsync_out", j), int'(hsync_out), int'(hsPat[j]));
        checkOutput($sformatf("stream%0d_vsync_out", j), int'(vsync_out), int'(vsPat[j]));
      end
    end
    hsync = 1'b0; vsync = 1'b0;

    // ---- newline at the last row wraps; an unknown code is consumed silently
    for (int i = 0; i < 35; i++) sendByte(8'h0A);
    checkCursor("nl_lastRow", 0, 36);
    for (int i = 0; i < 10; i++) sendByte(8'h01);
    checkCursor("nl_at10_36", 10, 36);
    sendByte(8'h0A);
    checkCursor("nl_wrap", 0, 0);
    sendByte(8'h41);
    checkCursor("code41_cursor", 0, 0);
    checkOutput("code41_in_ready", int'(in_ready), 1);
    readCell(0, 0, ch);
    checkOutput("code41_cell00", ch, 5);

    // ---- glyph at the very last cell wraps the cursor to (0,0)
    for (int i = 0; i < 36; i++) sendByte(8'h0A);
    for (int i = 0; i < 99; i++) sendByte(8'h02);
    checkCursor("glyph_lastCell", 99, 36);
    sendByte(8'h0F);
    checkCursor("glyph_wrap", 0, 0);
    readCell(99, 36, ch);
    checkOutput("glyph_cell99_36", ch, 15);

    // ---- clear command: exact duration, cursor home, data blanked
    sendByte(8'h0A);
    for (int i = 0; i < 3; i++) sendByte(8'h09);
    checkCursor("preClear", 3, 1);
    sendByte(8'h0C);
    checkOutput("clear_busy", int'(in_ready), 0);
    n = n + 1;
    waitClear(n);
    checkOutput("clear_cycles", n, 3700 - 1 + 1);
    checkCursor("clear_cursor", 0, 0);
    readCell(0, 0, ch);
    checkOutput("clear_cell00", ch, 0);
    readCell(99, 36, ch);
    checkOutput("clear_cell99_36", ch, 0);

    // ---- reset in the middle of a clear restarts a full clear
    sendByte(8'h09);
    sendByte(8'h0C);
    repeat (1000) @(posedge clk);
    #1;
    checkOutput("midClear_busy", int'(in_ready), 0);
    @(negedge clk);
    hsync = 1'b1;
    rst = 1'b1;
    #1;
    checkOutput("midClear_rst_hsync_out", int'(hsync_out), 0);
    checkCursor("midClear_rst_cursor", 0, 0);
    @(posedge clk); @(posedge clk); #1;
    checkOutput("midClear_rst_in_ready", int'(in_ready), 0);
    checkOutput("midClear_rst_character", int'(character), 0);
    @(negedge clk);
    hsync = 1'b0;
    rst = 1'b0;
    waitClear(n);
    checkOutput("restartClear_cycles", n, 3700);
    checkCursor("restartClear_cursor", 0, 0);
    readCell(0, 0, ch);
    checkOutput("restartClear_cell00", ch, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
